// File: rtl/icache_pf_pkg.sv
// Shared types, AXI encodings and line-address helper for the icache stream prefetcher.
package icache_pf_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} pf_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // Callers widen to 64 bits on entry and cast the result back to their address width.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned line_words);
    logic [63:0] mask;
    mask = 64'(line_words * 4) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/pf_line_store.sv
// Prefetched-line buffer: tag/valid/data per entry, parallel lookup, victim choice and write port.
module pf_line_store
  import icache_pf_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int ENTRIES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lk_valid,
  input  logic [ADDR_W-1:0]        lk_line,
  input  logic                     lk_take,
  output logic                     lk_hit,
  output logic [LINE_WORDS*32-1:0] lk_data,
  input  logic [ADDR_W-1:0]        probe_line,
  output logic                     probe_hit,
  input  logic                     flush,
  input  logic                     commit,
  input  logic [ADDR_W-1:0]        commit_tag,
  input  logic [LINE_WORDS*32-1:0] commit_data
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]        valid_q;
  logic [ADDR_W-1:0]         tag_q  [ENTRIES];
  logic [LINE_WORDS*32-1:0]  data_q [ENTRIES];
  logic [IDX_W-1:0]          rr_q;
  logic [IDX_W-1:0]          rr_d;
  logic [IDX_W-1:0]          victim_idx;
  logic [ENTRIES-1:0]        lk_match;
  logic [ENTRIES-1:0]        probe_match;
  logic [ENTRIES-1:0]        take_vec;
  logic [ENTRIES-1:0]        commit_vec;
  logic                      all_valid;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign lk_match[gi]    = valid_q[gi] && (tag_q[gi] == lk_line);
      // The probe sees the buffer as it will be after this cycle's take.
      assign probe_match[gi] = valid_q[gi] && !take_vec[gi] && (tag_q[gi] == probe_line);
      assign commit_vec[gi]  = commit && (victim_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (commit_vec[gi]) begin
          tag_q[gi]  <= commit_tag;
          data_q[gi] <= commit_data;
        end
      end
    end
  endgenerate

  assign lk_hit    = lk_valid && (|lk_match);
  assign probe_hit = |probe_match;
  assign take_vec  = (lk_take && lk_hit) ? lk_match : '0;
  assign all_valid = &valid_q;
  assign rr_d      = (rr_q == IDX_W'(ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);

  always_comb begin
    lk_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lk_match[i]) lk_data = lk_data | data_q[i];
    end
  end

  always_comb begin
    victim_idx = rr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      if (flush) valid_q <= '0;
      else       valid_q <= (valid_q & ~take_vec) | commit_vec;
      if (commit && !flush && all_valid) rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/icache_stream_prefetch.sv
// Next-line icache prefetcher: one AXI read burst per accepted trigger, filling pf_line_store.
// Build option PF_ERR_DROP_EN: drop any line that saw a non-OKAY rresp beat.
module icache_stream_prefetch
  import icache_pf_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          LINE_WORDS = 16,
  parameter int          ENTRIES    = 2,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trig_valid,
  input  logic [ADDR_W-1:0]        trig_addr,
  input  logic                     flush,
  input  logic                     lk_valid,
  input  logic [ADDR_W-1:0]        lk_addr,
  input  logic                     lk_take,
  output logic                     lk_hit,
  output logic                     lk_busy,
  output logic [LINE_WORDS*32-1:0] lk_data,
  output logic [3:0]               arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int CNT_W = $clog2(LINE_WORDS) + 1;

  pf_state_t               state_q;
  logic [ADDR_W-1:0]       tgt_q;
  logic [ADDR_W-1:0]       araddr_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    discard_q;
  logic [31:0]             fill_buf_q [LINE_WORDS];

  logic [ADDR_W-1:0]        trig_tgt;
  logic [ADDR_W-1:0]        lk_line;
  logic                     probe_hit;
  logic                     accept;
  logic                     beat;
  logic                     last_word;
  logic                     beat_err;
  logic                     discard_set;
  logic                     commit;
  logic [LINE_WORDS*32-1:0] commit_data;
  logic                     unused_axi;

  assign trig_tgt  = ADDR_W'(line_base(64'(trig_addr), LINE_WORDS)) + ADDR_W'(LINE_WORDS * 4);
  assign lk_line   = ADDR_W'(line_base(64'(lk_addr), LINE_WORDS));
  // A zero target means the trigger was in the top line; never wrap around.
  assign accept    = (state_q == IDLE) && trig_valid && (trig_tgt != '0) && !probe_hit;
  assign beat      = (state_q == DATA) && rvalid;
  assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));

`ifdef PF_ERR_DROP_EN
  assign beat_err = beat && (rresp != RESP_OKAY);
`else
  assign beat_err = 1'b0;
`endif
  assign unused_axi = ^{rid, rresp};

  assign discard_set = ((state_q != IDLE) && flush)
                     || (beat && rlast && !last_word)
                     || (beat && !rlast && last_word)
                     || beat_err;
  assign commit = beat && rlast && !discard_q && !discard_set;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      if (gi == LINE_WORDS - 1) begin : g_last
        assign commit_data[gi*32 +: 32] = rdata;
      end else begin : g_buf
        assign commit_data[gi*32 +: 32] = fill_buf_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (beat && !cnt_q[CNT_W-1]) fill_buf_q[cnt_q[CNT_W-2:0]] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tgt_q     <= trig_tgt;
            araddr_q  <= trig_tgt;
            arvalid_q <= 1'b1;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          discard_q <= discard_q | discard_set;
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          discard_q <= discard_q | discard_set;
          if (beat) begin
            if (!cnt_q[CNT_W-1]) cnt_q <= cnt_q + CNT_W'(1);
            if (rlast) begin
              rready_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pf_line_store #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS),
    .ENTRIES   (ENTRIES)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .lk_line    (lk_line),
    .lk_take    (lk_take),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data),
    .probe_line (trig_tgt),
    .probe_hit  (probe_hit),
    .flush      (flush),
    .commit     (commit),
    .commit_tag (tgt_q),
    .commit_data(commit_data)
  );

  assign lk_busy = lk_valid && (state_q != IDLE) && (tgt_q == lk_line) && !discard_q;

  assign arid    = 4'(AXI_ID);
  assign araddr  = araddr_q;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'd2;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule

// File: tb/tb_icache_stream_prefetch.sv
// Directed bench for icache_stream_prefetch (LINE_WORDS=16, ENTRIES=2) with a scripted AXI slave.
module tb_icache_stream_prefetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         trig_valid;
  logic [31:0]  trig_addr;
  logic         flush;
  logic         lk_valid;
  logic [31:0]  lk_addr;
  logic         lk_take;
  logic         lk_hit;
  logic         lk_busy;
  logic [511:0] lk_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [1:0]   arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache_stream_prefetch dut (
    .clk(clk), .rst(rst),
    .trig_valid(trig_valid), .trig_addr(trig_addr), .flush(flush),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_take(lk_take),
    .lk_hit(lk_hit), .lk_busy(lk_busy), .lk_data(lk_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic trig(input logic [31:0] a);
    @(negedge clk);
    trig_valid = 1'b1;
    trig_addr  = a;
    @(negedge clk);
    trig_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic look(input logic [31:0] a);
    lk_valid = 1'b1;
    lk_addr  = a;
    #1;
  endtask

  // Serves one burst: waits for AR, checks it, returns 16 beats of dbase+k.
  task automatic burst(input logic [31:0] exp_addr, input logic [31:0] dbase,
                       input int flush_beat, input int err_beat, input bit chk_busy);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (arvalid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ar_timeout: arvalid=%b, required 1 for araddr %h", arvalid, exp_addr);
      return;
    end
    total++;
    if (araddr !== exp_addr) begin
      bad++;
      $display("FAIL araddr: got %h, required %h", araddr, exp_addr);
    end
    total++;
    if ({arlen, arsize, arburst, arid} !== {8'd15, 3'd2, 2'b01, 4'd0}) begin
      bad++;
      $display("FAIL ar_fields: arlen=%0d arsize=%0d arburst=%0d arid=%0d, required 15/2/1/0",
               arlen, arsize, arburst, arid);
    end
    if (chk_busy) begin
      total++;
      if ({lk_busy, lk_hit} !== 2'b10) begin
        bad++;
        $display("FAIL busy_addr: busy=%b hit=%b, required busy=1 hit=0", lk_busy, lk_hit);
      end
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rvalid = 1'b1;
      rdata  = dbase + 32'(k);
      rlast  = (k == 15);
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      flush  = (k == flush_beat);
      #1;
      total++;
      if (rready !== 1'b1) begin
        bad++;
        $display("FAIL rready_beat%0d: got %b, required 1", k, rready);
      end
      if (chk_busy && k == 8) begin
        total++;
        if ({lk_busy, lk_hit} !== 2'b10) begin
          bad++;
          $display("FAIL busy_data: busy=%b hit=%b, required busy=1 hit=0", lk_busy, lk_hit);
        end
      end
      if (flush_beat >= 0 && k == flush_beat + 2) begin
        total++;
        if (lk_busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_after_flush: got %b, required 0", lk_busy);
        end
      end
      @(negedge clk);
      flush = 1'b0;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    $display("burst addr=%h data_base=%h flush_beat=%0d err_beat=%0d", exp_addr, dbase, flush_beat, err_beat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig_valid = 1'b0; trig_addr = '0; flush = 1'b0;
    lk_valid = 1'b1; lk_addr = '0; lk_take = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({arvalid, araddr, rready} !== 34'd0) begin
      bad++;
      $display("FAIL reset_axi: arvalid=%b araddr=%h rready=%b, required 0/0/0", arvalid, araddr, rready);
    end
    total++;
    if ({lk_hit, lk_busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_lookup: hit=%b busy=%b, required 0/0", lk_hit, lk_busy);
    end
    lk_valid = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [511:0] exp;
    for (int k = 0; k < 16; k++) exp[k*32 +: 32] = 32'(k);
    trig(32'h1000_0040);
    burst(32'h1000_0080, 32'h0, -1, -1, 1'b0);
    look(32'h1000_0084);
    total++;
    if (lk_hit !== 1'b1) begin
      bad++;
      $display("FAIL basic_hit: got %b, required 1", lk_hit);
    end
    total++;
    if (lk_data !== exp) begin
      bad++;
      $display("FAIL basic_data: word0=%h word15=%h, required 0 and f", lk_data[31:0], lk_data[511:480]);
    end
    lk_valid = 1'b0;
    $display("lookup 10000084 hit=%b", lk_hit);
  endtask

  task automatic test_busy_take();
    do_flush();
    look(32'h1000_0080);
    total++;
    if (lk_hit !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: hit=%b, required 0", lk_hit);
    end
    trig(32'h1000_0040);
    look(32'h1000_0080);
    burst(32'h1000_0080, 32'h100, -1, -1, 1'b1);
    #1;
    total++;
    if ({lk_hit, lk_busy} !== 2'b10) begin
      bad++;
      $display("FAIL commit_hit: hit=%b busy=%b, required 1/0", lk_hit, lk_busy);
    end
    lk_take = 1'b1;
    @(negedge clk);
    lk_take = 1'b0;
    #1;
    total++;
    if (lk_hit !== 1'b0) begin
      bad++;
      $display("FAIL take_clear: hit=%b, required 0", lk_hit);
    end
    lk_valid = 1'b0;
    $display("busy/take on line 10000080 done");
  endtask

  task automatic test_replace();
    do_flush();
    trig(32'h0000_00C0);
    burst(32'h0000_0100, 32'hA000, -1, -1, 1'b0);
    trig(32'h0000_0100);
    burst(32'h0000_0140, 32'hB000, -1, -1, 1'b0);
    trig(32'h0000_0140);
    burst(32'h0000_0180, 32'hC000, -1, -1, 1'b0);
    look(32'h0000_0100);
    total++;
    if (lk_hit !== 1'b0) begin
      bad++;
      $display("FAIL replaced_line: hit=%b, required 0", lk_hit);
    end
    look(32'h0000_0140);
    total++;
    if (lk_hit !== 1'b1 || lk_data[31:0] !== 32'hB000) begin
      bad++;
      $display("FAIL keep_140: hit=%b word0=%h, required 1/0000b000", lk_hit, lk_data[31:0]);
    end
    look(32'h0000_01BC);
    total++;
    if (lk_hit !== 1'b1 || lk_data[511:480] !== 32'hC00F) begin
      bad++;
      $display("FAIL keep_180: hit=%b word15=%h, required 1/0000c00f", lk_hit, lk_data[511:480]);
    end
    lk_valid = 1'b0;
    $display("replacement of line 100 checked");
  endtask

  task automatic test_flush_mid();
    trig(32'h0000_01C0);
    look(32'h0000_0200);
    burst(32'h0000_0200, 32'hD000, 5, -1, 1'b0);
    look(32'h0000_0200);
    total++;
    if (lk_hit !== 1'b0) begin
      bad++;
      $display("FAIL flush_discard: hit=%b, required 0", lk_hit);
    end
    look(32'h0000_0180);
    total++;
    if (lk_hit !== 1'b0) begin
      bad++;
      $display("FAIL flush_invalidate: hit=%b, required 0", lk_hit);
    end
    lk_valid = 1'b0;
    $display("flush mid-burst checked");
  endtask

  task automatic test_no_issue();
    bit seen;
    trig(32'hFFFF_FFC4);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (arvalid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL top_line_wrap: arvalid seen=1, required 0");
    end
    trig(32'h0000_0300);
    burst(32'h0000_0340, 32'hE000, -1, -1, 1'b0);
    trig(32'h0000_0300);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (arvalid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL dup_trigger: arvalid seen=1, required 0");
    end
    // Take of the valid line in the same cycle as a trigger for it lets the trigger through.
    lk_valid = 1'b1; lk_addr = 32'h0000_0340; lk_take = 1'b1;
    trig_valid = 1'b1; trig_addr = 32'h0000_0300;
    @(negedge clk);
    lk_valid = 1'b0; lk_take = 1'b0; trig_valid = 1'b0;
    burst(32'h0000_0340, 32'hE100, -1, -1, 1'b0);
    look(32'h0000_0340);
    total++;
    if (lk_hit !== 1'b1 || lk_data[31:0] !== 32'hE100) begin
      bad++;
      $display("FAIL take_trigger: hit=%b word0=%h, required 1/0000e100", lk_hit, lk_data[31:0]);
    end
    lk_valid = 1'b0;
    $display("suppressed triggers checked");
  endtask

  task automatic test_err();
    logic exp_hit;
`ifdef PF_ERR_DROP_EN
    exp_hit = 1'b0;
`else
    exp_hit = 1'b1;
`endif
    trig(32'h0000_0400);
    burst(32'h0000_0440, 32'hF000, -1, 3, 1'b0);
    look(32'h0000_0440);
    total++;
    if (lk_hit !== exp_hit) begin
      bad++;
      $display("FAIL slverr_commit: hit=%b, required %b", lk_hit, exp_hit);
    end
    lk_valid = 1'b0;
    $display("slverr line 440 hit=%b", lk_hit);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_take();
    test_replace();
    test_flush_mid();
    test_no_issue();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
